// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode-side
// instruction handshake and redirect inputs.
interface instruction_fetch_unit_if;
  // Handshakes: imem_req holds imem_addr steady until the cycle imem_ready=1.
  // instr_valid holds instr_out/pc_out/pc_plus4 steady until instr_ready=1.
  // A transfer happens only in a cycle where both sides of a pair are high.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        redirect_br;
  logic [31:0] br_offset;
  logic        redirect_j;
  logic [25:0] j_index;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4,
    input  imem_ready, imem_rdata, instr_ready, redirect_br, br_offset,
           redirect_j, j_index
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4,
    output imem_ready, imem_rdata, instr_ready, redirect_br, br_offset,
           redirect_j, j_index
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch: IDLE -> REQ (wait memory) -> HOLD
// (wait decode), with branch/jump redirects applied when decode accepts.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  instruction_fetch_unit_if.master       bus,
  output logic [1:0]                     state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_q, pc_out_q, pc_plus4_q;
  logic        valid_q;
  logic        fetch_done;
  logic        accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // imem_ready is only looked at in REQ, so stray responses elsewhere are inert.
  always_comb begin
    state_next = state;
    fetch_done = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: if (enable) state_next = REQ;
      REQ: begin
        if (bus.imem_ready) begin
          fetch_done = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && bus.instr_ready) begin
          accept     = 1'b1;
          state_next = enable ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // pc already points past the held instruction; a redirect replaces it,
  // so the next fetch comes straight from the target (no delay slot).
  always_comb begin
    pc_next = pc;
    if (fetch_done) begin
      pc_next = pc + 32'd4;
    end else if (accept) begin
      if (bus.redirect_j)
        pc_next = {pc_plus4_q[31:28], bus.j_index, 2'b00};
      else if (bus.redirect_br)
        pc_next = pc_plus4_q + (bus.br_offset << 2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC_ALIGNED;
      instr_q    <= 32'h0;
      pc_out_q   <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      pc <= pc_next;
      if (fetch_done) begin
        instr_q    <= bus.imem_rdata;
        pc_out_q   <= pc;
        pc_plus4_q <= pc + 32'd4;
        valid_q    <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.pc_plus4    = pc_plus4_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: inputs driven and outputs
// sampled on the falling edge, DUT acts on the rising edge.
module tb_instruction_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  instruction_fetch_unit_if ifu_bus ();

  // Low bits set on purpose: the fetch address must still start at 0.
  instruction_fetch_unit #(.RESET_PC(32'h0000_0003)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .bus       (ifu_bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_fetch_response(input logic [31:0] data);
    ifu_bus.imem_ready = 1'b1;
    ifu_bus.imem_rdata = data;
    @(negedge clk);
    ifu_bus.imem_ready = 1'b0;
    ifu_bus.imem_rdata = 32'h0;
  endtask

  task automatic drive_accept(input logic j, input logic [25:0] idx,
                              input logic br, input logic [31:0] off);
    ifu_bus.instr_ready = 1'b1;
    ifu_bus.redirect_j  = j;
    ifu_bus.j_index     = idx;
    ifu_bus.redirect_br = br;
    ifu_bus.br_offset   = off;
    @(negedge clk);
    ifu_bus.instr_ready = 1'b0;
    ifu_bus.redirect_j  = 1'b0;
    ifu_bus.j_index     = 26'h0;
    ifu_bus.redirect_br = 1'b0;
    ifu_bus.br_offset   = 32'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    ifu_bus.imem_ready = 1'b0;  ifu_bus.imem_rdata = 32'h0;
    ifu_bus.instr_ready = 1'b0; ifu_bus.redirect_br = 1'b0;
    ifu_bus.br_offset = 32'h0;  ifu_bus.redirect_j = 1'b0;
    ifu_bus.j_index = 26'h0;
    @(negedge clk);
    checks++; if (ifu_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", ifu_bus.imem_req); end
    checks++; if (ifu_bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ifu_bus.instr_valid); end
    checks++; if (ifu_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 00000000", ifu_bus.imem_addr); end
    checks++; if (ifu_bus.instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 00000000", ifu_bus.instr_out); end
    checks++; if (ifu_bus.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h exp 00000000", ifu_bus.pc_out); end
    checks++; if (ifu_bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc_plus4: got %h exp 00000000", ifu_bus.pc_plus4); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ifu_bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b exp 0", ifu_bus.imem_req); end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(k * 4);
      checks++; if (ifu_bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req: got %b exp 1", ifu_bus.imem_req); end
      checks++; if (ifu_bus.imem_addr !== exp_pc) begin errors++; $display("FAIL seq_addr: got %h exp %h", ifu_bus.imem_addr, exp_pc); end
      drive_fetch_response(32'hA000_0000 + 32'(k));
      checks++; if (ifu_bus.instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b exp 1", ifu_bus.instr_valid); end
      checks++; if (ifu_bus.instr_out !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL seq_instr: got %h exp %h", ifu_bus.instr_out, 32'hA000_0000 + 32'(k)); end
      checks++; if (ifu_bus.pc_out !== exp_pc) begin errors++; $display("FAIL seq_pc_out: got %h exp %h", ifu_bus.pc_out, exp_pc); end
      checks++; if (ifu_bus.pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pc_plus4: got %h exp %h", ifu_bus.pc_plus4, exp_pc + 32'd4); end
      checks++; if (ifu_bus.imem_req !== 1'b0) begin errors++; $display("FAIL seq_hold_req: got %b exp 0", ifu_bus.imem_req); end
      drive_accept(1'b0, 26'h0, 1'b0, 32'h0);
    end
    // Request for 0xC is now outstanding; dropping enable must not cancel it.
    enable = 1'b0;
  endtask

  task automatic test_wait_states();
    for (int w = 0; w < 3; w++) begin
      checks++; if (ifu_bus.imem_req !== 1'b1 || ifu_bus.imem_addr !== 32'hC) begin errors++; $display("FAIL wait_req_stable: got req=%b addr=%h exp req=1 addr=0000000c", ifu_bus.imem_req, ifu_bus.imem_addr); end
      checks++; if (ifu_bus.instr_valid !== 1'b0) begin errors++; $display("FAIL wait_no_valid: got %b exp 0", ifu_bus.instr_valid); end
      @(negedge clk);
    end
    checks++; if (ifu_bus.imem_req !== 1'b1 || ifu_bus.imem_addr !== 32'hC) begin errors++; $display("FAIL wait_req_last: got req=%b addr=%h exp req=1 addr=0000000c", ifu_bus.imem_req, ifu_bus.imem_addr); end
    drive_fetch_response(32'h1234_5678);
    checks++; if (ifu_bus.instr_valid !== 1'b1) begin errors++; $display("FAIL wait_valid: got %b exp 1", ifu_bus.instr_valid); end
    checks++; if (ifu_bus.instr_out !== 32'h1234_5678) begin errors++; $display("FAIL wait_instr: got %h exp 12345678", ifu_bus.instr_out); end
    checks++; if (ifu_bus.pc_out !== 32'hC || ifu_bus.pc_plus4 !== 32'h10) begin errors++; $display("FAIL wait_pc: got %h/%h exp 0000000c/00000010", ifu_bus.pc_out, ifu_bus.pc_plus4); end
  endtask

  task automatic test_hold_stall();
    ifu_bus.imem_ready  = 1'b1;
    ifu_bus.imem_rdata  = 32'hBAD0_BAD0;
    ifu_bus.redirect_j  = 1'b1;
    ifu_bus.j_index     = 26'h3FF_FFFF;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (ifu_bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b exp 1", ifu_bus.instr_valid); end
      checks++; if (ifu_bus.instr_out !== 32'h1234_5678) begin errors++; $display("FAIL stall_instr: got %h exp 12345678", ifu_bus.instr_out); end
      checks++; if (ifu_bus.pc_out !== 32'hC) begin errors++; $display("FAIL stall_pc_out: got %h exp 0000000c", ifu_bus.pc_out); end
      checks++; if (ifu_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b exp 0", ifu_bus.imem_req); end
    end
    ifu_bus.imem_ready = 1'b0;
    ifu_bus.redirect_j = 1'b0;
    ifu_bus.j_index    = 26'h0;
    drive_accept(1'b0, 26'h0, 1'b0, 32'h0);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL accept_to_idle: got %0d exp 0", state_dbg); end
    checks++; if (ifu_bus.instr_valid !== 1'b0) begin errors++; $display("FAIL accept_clears_valid: got %b exp 0", ifu_bus.instr_valid); end
    checks++; if (ifu_bus.imem_addr !== 32'h10) begin errors++; $display("FAIL stall_redirect_ignored: got %h exp 00000010", ifu_bus.imem_addr); end
    ifu_bus.imem_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++; if (ifu_bus.instr_valid !== 1'b0 || ifu_bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_ready_ignored: got valid=%b req=%b exp 0/0", ifu_bus.instr_valid, ifu_bus.imem_req); end
    end
    ifu_bus.imem_ready = 1'b0;
  endtask

  task automatic test_redirects();
    enable = 1'b1;
    @(negedge clk);
    checks++; if (ifu_bus.imem_addr !== 32'h10) begin errors++; $display("FAIL redir_start_addr: got %h exp 00000010", ifu_bus.imem_addr); end
    drive_fetch_response(32'h0800_0000);
    drive_accept(1'b1, 26'h40, 1'b0, 32'h0);
    checks++; if (ifu_bus.imem_req !== 1'b1 || ifu_bus.imem_addr !== 32'h100) begin errors++; $display("FAIL jump_to_100: got req=%b addr=%h exp 1/00000100", ifu_bus.imem_req, ifu_bus.imem_addr); end
    drive_fetch_response(32'h1111_0001);
    checks++; if (ifu_bus.pc_out !== 32'h100 || ifu_bus.pc_plus4 !== 32'h104) begin errors++; $display("FAIL target_pc: got %h/%h exp 00000100/00000104", ifu_bus.pc_out, ifu_bus.pc_plus4); end
    drive_accept(1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE);
    checks++; if (ifu_bus.imem_addr !== 32'h0FC) begin errors++; $display("FAIL branch_back: got %h exp 000000fc", ifu_bus.imem_addr); end
    drive_fetch_response(32'h1111_0002);
    drive_accept(1'b0, 26'h0, 1'b1, 32'h03FF_FFC0);
    checks++; if (ifu_bus.imem_addr !== 32'h1000_0000) begin errors++; $display("FAIL branch_far: got %h exp 10000000", ifu_bus.imem_addr); end
    drive_fetch_response(32'h1111_0003);
    checks++; if (ifu_bus.pc_out !== 32'h1000_0000) begin errors++; $display("FAIL far_pc_out: got %h exp 10000000", ifu_bus.pc_out); end
    drive_accept(1'b1, 26'h40, 1'b0, 32'h0);
    checks++; if (ifu_bus.imem_addr !== 32'h1000_0100) begin errors++; $display("FAIL jump_region: got %h exp 10000100", ifu_bus.imem_addr); end
    drive_fetch_response(32'h1111_0004);
    drive_accept(1'b1, 26'h80, 1'b1, 32'hFFFF_FFFE);
    checks++; if (ifu_bus.imem_addr !== 32'h1000_0200) begin errors++; $display("FAIL jump_priority: got %h exp 10000200", ifu_bus.imem_addr); end
  endtask

  task automatic test_wrap();
    drive_fetch_response(32'h2222_0001);
    drive_accept(1'b0, 26'h0, 1'b1, 32'h3BFF_FF7E);
    checks++; if (ifu_bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL branch_top: got %h exp fffffffc", ifu_bus.imem_addr); end
    drive_fetch_response(32'h2222_0002);
    checks++; if (ifu_bus.pc_out !== 32'hFFFF_FFFC || ifu_bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h/%h exp fffffffc/00000000", ifu_bus.pc_out, ifu_bus.pc_plus4); end
    drive_accept(1'b0, 26'h0, 1'b0, 32'h0);
    checks++; if (ifu_bus.imem_req !== 1'b1 || ifu_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got req=%b addr=%h exp 1/00000000", ifu_bus.imem_req, ifu_bus.imem_addr); end
  endtask

  task automatic test_reset_mid_req();
    drive_fetch_response(32'h3333_0001);
    drive_accept(1'b0, 26'h0, 1'b0, 32'h0);
    checks++; if (ifu_bus.imem_addr !== 32'h4) begin errors++; $display("FAIL pre_reset_addr: got %h exp 00000004", ifu_bus.imem_addr); end
    rst_n = 1'b0;
    ifu_bus.imem_ready = 1'b1;
    ifu_bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (ifu_bus.imem_req !== 1'b0 || ifu_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL async_reset: got req=%b addr=%h exp 0/00000000", ifu_bus.imem_req, ifu_bus.imem_addr); end
    checks++; if (state_dbg !== 2'd0 || ifu_bus.pc_out !== 32'h0) begin errors++; $display("FAIL async_reset_state: got state=%0d pc_out=%h exp 0/00000000", state_dbg, ifu_bus.pc_out); end
    @(negedge clk);
    checks++; if (ifu_bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_ready_ignored: got %b exp 0", ifu_bus.instr_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ifu_bus.instr_valid !== 1'b0) begin errors++; $display("FAIL post_reset_ready_ignored: got %b exp 0", ifu_bus.instr_valid); end
    checks++; if (ifu_bus.imem_req !== 1'b1 || ifu_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL refetch: got req=%b addr=%h exp 1/00000000", ifu_bus.imem_req, ifu_bus.imem_addr); end
    ifu_bus.imem_ready = 1'b0;
    drive_fetch_response(32'h5555_AAAA);
    checks++; if (ifu_bus.instr_valid !== 1'b1 || ifu_bus.instr_out !== 32'h5555_AAAA || ifu_bus.pc_out !== 32'h0) begin errors++; $display("FAIL refetch_data: got valid=%b instr=%h pc=%h exp 1/5555aaaa/00000000", ifu_bus.instr_valid, ifu_bus.instr_out, ifu_bus.pc_out); end
    enable = 1'b0;
    drive_accept(1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_hold_stall();
    test_redirects();
    test_wrap();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] SHALL be treated as 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  permits new fetch requests.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ready  input  1  memory response strobe; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instruction available to decode.
REQ-010 instr_ready  input  1  decode accepts instruction.
REQ-011 instr_out  output  32  instruction word; [15:0] is the immediate field fed to sign extension.
REQ-012 pc_out  output  32  address of instr_out.
REQ-013 pc_plus4  output  32  pc_out + 4.
REQ-014 redirect_br  input  1  taken branch for instruction being accepted.
REQ-015 br_offset  input  32  sign-extended 16-bit branch immediate (word offset).
REQ-016 redirect_j  input  1  jump for instruction being accepted.
REQ-017 j_index  input  26  jump target index.

Function
REQ-018 FSM SHALL have exactly three states: IDLE, REQ, HOLD.
REQ-019 IDLE: enable=1 -> REQ next cycle; else stay IDLE.
REQ-020 REQ: imem_req=1 and imem_addr=pc, both stable until the cycle imem_ready=1.
REQ-021 REQ with imem_ready=1: instr_out<=imem_rdata, pc_out<=pc, pc_plus4<=pc+4, pc<=pc+4, instr_valid<=1, -> HOLD.
REQ-022 enable deasserted during REQ SHALL NOT abort the outstanding request.
REQ-023 HOLD: instr_valid=1; instr_out, pc_out, pc_plus4 stable until instr_ready=1.
REQ-024 HOLD with instr_ready=1: instr_valid<=0; -> REQ if enable=1, else IDLE.
REQ-025 Redirects SHALL be sampled only when instr_valid=1 and instr_ready=1; otherwise ignored.
REQ-026 redirect_br accepted: pc<=pc_plus4 + (br_offset<<2), arithmetic modulo 2^32.
REQ-027 redirect_j accepted: pc<={pc_plus4[31:28], j_index, 2'b00}.
REQ-028 Both redirects asserted together: jump SHALL take priority.
REQ-029 No delay slot: instruction after a redirect SHALL be fetched from the target.
REQ-030 imem_ready outside REQ SHALL be ignored (no state or output change).
REQ-031 imem_addr[1:0] SHALL always be 2'b00.
REQ-032 imem_req=0 in IDLE and HOLD; imem_addr=pc in all states.
REQ-033 Minimum issue interval: one instruction per two cycles with zero-wait memory and instr_ready held high.

Reset
REQ-034 rst_n=0 SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, pc_out=0, pc_plus4=0.
REQ-035 Reset during REQ or HOLD SHALL abandon the transaction; a later imem_ready SHALL be ignored.
REQ-036 First request after rst_n release SHALL occur the cycle after enable=1 is sampled in IDLE.

Verification
REQ-037 Reset, enable=1, zero-wait memory, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; pc_out matches; pc_plus4=pc_out+4.
REQ-038 imem_ready delayed 3 cycles -> imem_req/imem_addr stable for all 4 REQ cycles; one instruction delivered.
REQ-039 instr_ready low 5 cycles in HOLD -> instr_out/pc_out unchanged, no new imem_req.
REQ-040 pc_out=0x100, redirect_br=1, br_offset=0xFFFF_FFFE on accept -> next imem_addr=0x0FC; redirect_j=1, j_index=0x0000040 from pc_out=0x1000_0000 -> 0x1000_0100; both high -> jump target.
REQ-041 pc_out=0xFFFF_FFFC, sequential fetch -> next imem_addr=0x0000_0000 (wrap).
REQ-042 rst_n pulsed low mid-REQ, imem_ready asserted during reset and next cycle -> instr_valid stays 0, pc=RESET_PC, refetch from RESET_PC.
